// File: rtl/ps2_key_rx_if.sv
// ps2_key_rx_if: groups the PS/2 pin pair and the decoded key-event outputs.
//   ps2_clk   - raw PS/2 clock line, asynchronous to the system clock
//   ps2_data  - raw PS/2 data line, asynchronous to the system clock
//   ps2_key   - 11-bit event word {toggle, pressed, extended, code[7:0]}
//   frame_err - one-cycle pulse per rejected or timed-out frame
// master: keyboard/pin side (drives the lines, observes the events)
// slave : the receiver (samples the lines, drives the events)
interface ps2_key_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_err;

  modport master (output ps2_clk, output ps2_data, input ps2_key, input frame_err);
  modport slave  (input ps2_clk, input ps2_data, output ps2_key, output frame_err);
endinterface

// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver producing the 11-bit ps2_key event word.
// Synchronizes and glitch-filters the PS/2 clock, shifts in 11-bit frames
// (start, 8 data LSB first, odd parity, stop), and folds E0/F0/E1 prefixes
// into one event per key: {toggle, pressed, extended, scancode}.
// Ports:
//   clk_sys - system clock, all logic on its rising edge
//   reset   - synchronous, active-high
//   bus     - ps2_key_rx_if.slave (ps2_clk, ps2_data in; ps2_key, frame_err out)
// Parameters:
//   CLK_FILTER - consecutive equal samples before the filtered clock moves (2..255)
//   TIMEOUT    - idle cycles (no strobe) before a partial frame is aborted
module ps2_key_rx #(
  parameter int CLK_FILTER = 8,
  parameter int TIMEOUT    = 12000
) (
  input  logic         clk_sys,
  input  logic         reset,
  ps2_key_rx_if.slave  bus
);

  localparam logic [7:0] FILT_LAST = 8'(CLK_FILTER - 1);
  localparam int         TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_t;

  // ---------------------------------------------------------------- sync
  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge value of its neighbours, exactly like the flops it models.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], bus.ps2_clk};
      r_data_sync <= {r_data_sync[0], bus.ps2_data};
    end
  end

  // -------------------------------------------------------- clock filter
  // The filtered level flips on the CLK_FILTER-th consecutive differing
  // sample; the high-to-low flip cycle is the bit strobe.
  logic [7:0] r_filt_cnt;
  logic       r_clk_filt;
  logic       w_differs;
  logic       w_flip;
  logic       w_strobe;
  logic       w_data;

  assign w_differs = (r_clk_sync[1] != r_clk_filt);
  assign w_flip    = w_differs && (r_filt_cnt == FILT_LAST);
  assign w_strobe  = w_flip && r_clk_filt;
  assign w_data    = r_data_sync[1];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_filt_cnt <= 8'd0;
      r_clk_filt <= 1'b1;
    end else if (!w_differs) begin
      r_filt_cnt <= 8'd0;
    end else if (w_flip) begin
      r_filt_cnt <= 8'd0;
      r_clk_filt <= ~r_clk_filt;
    end else begin
      r_filt_cnt <= r_filt_cnt + 8'd1;
    end
  end

  // ----------------------------------------------------- frame receiver
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_par_bit;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_frame_err;
  logic             w_stop;
  logic             w_frame_good;
  logic             w_byte_ok;
  logic             w_byte_bad;
  logic             w_tmo_hit;

  // Odd parity: data plus parity bit carries an odd number of ones.
  assign w_stop       = w_strobe && (r_bit_cnt == 4'd10);
  assign w_frame_good = w_data && (^{r_shift, r_par_bit});
  assign w_byte_ok    = w_stop && w_frame_good;
  assign w_byte_bad   = w_stop && !w_frame_good;
  // A strobe in the expiry cycle takes priority, so it is excluded here.
  assign w_tmo_hit    = !w_strobe && (r_bit_cnt != 4'd0) && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'd0;
      r_par_bit   <= 1'b0;
      r_tmo_cnt   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_byte_bad || w_tmo_hit;
      if (w_strobe) begin
        r_tmo_cnt <= '0;
        if (r_bit_cnt == 4'd0) begin
          // A high start bit is treated as noise: stay aligned at bit 0.
          if (!w_data) r_bit_cnt <= 4'd1;
        end else if (r_bit_cnt <= 4'd8) begin
          r_shift   <= {w_data, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end else if (r_bit_cnt == 4'd9) begin
          r_par_bit <= w_data;
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end else begin
          r_bit_cnt <= 4'd0;
        end
      end else if (r_bit_cnt == 4'd0) begin
        r_tmo_cnt <= '0;
      end else if (w_tmo_hit) begin
        r_bit_cnt <= 4'd0;
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
    end
  end

  // ------------------------------------------------------ assembler FSM
  state_t      r_state;
  logic [2:0]  r_skip_cnt;
  logic [10:0] r_ps2_key;
  logic        w_is_ext;
  logic        w_is_brk;

  assign w_is_ext = (r_state == S_EXT) || (r_state == S_EXT_BRK);
  assign w_is_brk = (r_state == S_BRK) || (r_state == S_EXT_BRK);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_skip_cnt <= 3'd0;
      r_ps2_key  <= 11'h000;
    end else if (w_byte_bad) begin
      // A corrupted byte may have been a prefix; drop any pending prefix.
      r_state    <= S_IDLE;
      r_skip_cnt <= 3'd0;
    end else if (w_byte_ok) begin
      if (r_state == S_SKIP) begin
        // E1 pause sequence: swallow the next seven good bytes.
        r_skip_cnt <= r_skip_cnt - 3'd1;
        if (r_skip_cnt == 3'd1) r_state <= S_IDLE;
      end else begin
        case (r_shift)
          8'hE0: begin
            if (r_state == S_IDLE)     r_state <= S_EXT;
            else if (r_state == S_BRK) r_state <= S_EXT_BRK;
          end
          8'hF0: begin
            if (r_state == S_IDLE)     r_state <= S_BRK;
            else if (r_state == S_EXT) r_state <= S_EXT_BRK;
          end
          8'hE1: begin
            r_state    <= S_SKIP;
            r_skip_cnt <= 3'd7;
          end
          default: begin
            r_ps2_key <= {~r_ps2_key[10], ~w_is_brk, w_is_ext, r_shift};
            r_state   <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.ps2_key   = r_ps2_key;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx: directed bench for ps2_key_rx. A flag-based prefix model
// predicts the event word; a per-cycle compare process checks it, counts
// ps2_key changes and frame_err pulses, and literals pin key results.
module tb_ps2_key_rx;
  localparam int CLK_FILTER = 8;
  localparam int TIMEOUT    = 400;
  localparam int HALF       = 20;   // PS/2 half bit period in clk_sys cycles

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  ps2_key_rx_if bus ();

  ps2_key_rx #(.CLK_FILTER(CLK_FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks    = 0;
  int n_fail      = 0;
  int key_changes = 0;
  int err_pulses  = 0;
  bit chk_en      = 1'b0;

  // Model: pending prefix flags and number of bytes still to swallow.
  logic [10:0] m_key  = 11'h000;
  bit          m_ext  = 1'b0;
  bit          m_brk  = 1'b0;
  int          m_skip = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic model_reset();
    m_key = 11'h000; m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, output int ev);
    ev = 0;
    if (m_skip > 0)      m_skip--;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE1) m_skip = 7;
    else begin
      m_key = {~m_key[10], ~m_brk, m_ext, b};
      m_ext = 1'b0;
      m_brk = 1'b0;
      ev    = 1;
    end
  endtask

  // Drive n frame bits, bit 0 first; data moves mid-way through clock high.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      tick(HALF / 2);
      bus.ps2_clk = 1'b0;
      tick(HALF);
      bus.ps2_clk = 1'b1;
      tick(HALF / 2);
    end
    bus.ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b, input bit bad_par);
    logic par;
    par = (~^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    int e0;
    int ev;
    chk_en      = 1'b0;
    key_changes = 0;
    e0          = err_pulses;
    send_bits(frame_of(b, bad_par), 11);
    tick(10);
    if (bad_par) begin
      m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
      ev = 0;
    end else begin
      model_byte(b, ev);
    end
    check($sformatf("events_%02h", b), key_changes, ev);
    check($sformatf("frame_err_%02h", b), err_pulses - e0, bad_par ? 1 : 0);
    chk_en = 1'b1;
  endtask

  // Compare process: runs every cycle on the falling edge.
  initial begin : compare
    logic [10:0] prev_key;
    logic        prev_err;
    prev_key = 11'h000;
    prev_err = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        prev_key = bus.ps2_key;
        prev_err = 1'b0;
      end else begin
        if (bus.ps2_key !== prev_key) key_changes++;
        if (bus.frame_err === 1'b1) begin
          err_pulses++;
          check("err_pulse_width", {prev_err, bus.frame_err}, 2'b01);
        end
        if (chk_en) check("key_vs_model", bus.ps2_key, m_key);
        prev_key = bus.ps2_key;
        prev_err = bus.frame_err;
      end
    end
  end

  initial begin : stimulus
    int e0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset        = 1'b1;
    tick(4);
    check("reset_key", bus.ps2_key, 11'h000);
    check("reset_err", bus.frame_err, 1'b0);
    reset = 1'b0;
    model_reset();
    tick(5);
    chk_en = 1'b1;

    // Make code
    send_byte(8'h1C, 1'b0);
    check("make_lit", bus.ps2_key, 11'h61C);

    // Extended break: only the final byte produces an event
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    check("ext_brk_lit", bus.ps2_key, 11'h175);

    // Parity error on a break prefix clears it
    send_byte(8'hF0, 1'b1);
    send_byte(8'h14, 1'b0);
    check("after_perr_lit", bus.ps2_key, 11'h614);

    // Timeout on a partial frame
    chk_en      = 1'b0;
    key_changes = 0;
    e0          = err_pulses;
    send_bits(frame_of(8'h3C, 1'b0), 5);
    tick(TIMEOUT + 50);
    check("timeout_err", err_pulses - e0, 1);
    check("timeout_events", key_changes, 0);
    chk_en = 1'b1;
    send_byte(8'h16, 1'b0);
    check("after_tmo_lit", bus.ps2_key, 11'h216);

    // Pause sequence swallows eight bytes
    send_byte(8'hE1, 1'b0);
    send_byte(8'h14, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'hE1, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h14, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h29, 1'b0);
    check("pause_lit", bus.ps2_key[9:0], 10'h229);

    // Clock glitch one sample short of the filter length
    e0          = err_pulses;
    key_changes = 0;
    bus.ps2_data = 1'b0;
    tick(4);
    bus.ps2_clk = 1'b0;
    tick(CLK_FILTER - 1);
    bus.ps2_clk = 1'b1;
    tick(4);
    bus.ps2_data = 1'b1;
    tick(50);
    check("glitch_events", key_changes, 0);
    send_byte(8'h33, 1'b0);
    check("after_glitch_lit", bus.ps2_key, 11'h233);
    check("glitch_err", err_pulses - e0, 0);

    // Self-test code goes through unfiltered
    send_byte(8'hAA, 1'b0);
    check("aa_lit", bus.ps2_key, 11'h6AA);

    // Reset mid-prefix and mid-frame discards everything
    send_byte(8'hF0, 1'b0);
    e0     = err_pulses;
    chk_en = 1'b0;
    send_bits(frame_of(8'h5A, 1'b0), 3);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    model_reset();
    tick(1);
    check("mid_reset_key", bus.ps2_key, 11'h000);
    chk_en = 1'b1;
    tick(20);
    send_byte(8'h5A, 1'b0);
    check("after_reset_lit", bus.ps2_key, 11'h65A);
    check("reset_no_err", err_pulses - e0, 0);

    tick(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
